node_nic: RTL and testbench
===========================

// Module: node_nic
// PURPOSE
//  Node-side network interface: the end of the node<->network valid/enable link that faces the mesh.
//  Buffers packets from the local node core into a TX FIFO and injects them when the network enables.
//  Captures packets ejected by the local router into an RX FIFO drained by the core; counts traffic.
//  One instance per node, sitting between the node core and the network's per-node i_data/o_data slot.
// PARAMETERS
//  PKT_W      32  packet width in bits; must equal $bits(packet_t)
//  TX_DEPTH   4   TX FIFO entries, power of 2, >=2
//  RX_DEPTH   4   RX FIFO entries, power of 2, >=2
//  CNT_W      16  width of traffic counters
// PORTS
//  clk         in   1        clock, all state on posedge
//  reset       in   1        asynchronous, active-high reset
//  src_data    in   PKT_W    packet from node core
//  src_val     in   1        src_data valid
//  src_rdy     out  1        TX FIFO can accept (not full)
//  net_o_data  out  PKT_W    packet to network (network's i_data for this node)
//  net_o_val   out  1        net_o_data valid (network's i_data_val)
//  net_i_en    in   1        network enables this node to send (network's o_en)
//  net_i_data  in   PKT_W    packet from network (network's o_data)
//  net_i_val   in   1        net_i_data valid (network's o_data_val); no backpressure exists
//  sink_data   out  PKT_W    RX FIFO head to node core
//  sink_val    out  1        RX FIFO not empty
//  sink_rdy    in   1        core consumes head this cycle
//  tx_cnt      out  CNT_W    packets injected into network
//  rx_cnt      out  CNT_W    packets accepted from network into RX FIFO
//  rx_drop     out  1        sticky: an ejected packet was lost to a full RX FIFO
// BEHAVIOUR
//  Reset: both FIFOs empty, pointers 0; src_rdy=0 while reset high, 1 first cycle after release;
//   net_o_val=0, net_o_data=0, sink_val=0, sink_data=0, tx_cnt=0, rx_cnt=0, rx_drop=0.
//  Reset mid-operation discards all buffered packets; no partial transfer completes in the reset cycle.
//  TX push: src_val && src_rdy at posedge writes src_data. src_rdy = !tx_full (registered-state based).
//  TX injection: net_o_val = !tx_empty && net_i_en (combinational); net_o_data = TX head, 0 when empty.
//   Transfer on posedge when net_o_val=1: pop head, tx_cnt+1. net_o_val never asserts while net_i_en=0.
//  TX latency: packet pushed at edge N is visible at head by cycle N+1; injects first en cycle >=N+1.
//  TX order strictly FIFO; simultaneous push+pop when full is not permitted (src_rdy=0);
//   simultaneous push+pop when non-full keeps occupancy constant.
//  RX capture: net_i_val at posedge writes net_i_data if !rx_full OR (sink_val && sink_rdy) same cycle
//   (pop frees slot); rx_cnt+1 on each write.
//  RX overflow: net_i_val with rx_full and no pop -> packet discarded, rx_drop set, held until reset.
//  RX drain: sink_val = !rx_empty; sink_data = head (0 when empty); sink_rdy && sink_val pops.
//   sink_rdy while empty is ignored. Packet written at edge N appears on sink_data in cycle N+1.
//  FIFOs: pointers log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full = MSBs differ & low bits equal.
//  Counters wrap modulo 2^CNT_W silently (0xFFFF+1 -> 0x0000 at default).
//  TX and RX paths are independent; all four events (push, inject, capture, drain) may coincide.
// TESTING
//  Reset then push 0xA1,0xA2,0xA3 with net_i_en=1 -> net_o_data 0xA1,0xA2,0xA3 on consecutive cycles; tx_cnt=3.
//  net_i_en=0, push 5 packets -> 4 accepted, src_rdy=0 after 4th, net_o_val=0; raise en -> 4 injected in order.
//  net_i_val 0xB0..0xB4 over 5 cycles, sink_rdy=0 -> 0xB0..0xB3 buffered, 0xB4 dropped, rx_drop=1, rx_cnt=4.
//  RX full, net_i_val=0xC5 with sink_rdy=1 same cycle -> no drop, 0xC5 becomes 4th entry, rx_cnt+1.
//  Preload tx_cnt to 0xFFFF via 65535 injections, inject one more -> tx_cnt=0x0000.
//  Assert reset with 2 TX and 3 RX packets queued -> all outputs zero next cycle, none later appear.

Source files
------------

// File: rtl/node_nic.sv
// node_nic: node-side network interface.
// TX FIFO buffers packets from the node core and injects them into the mesh
// whenever the network enables this node. RX FIFO captures packets ejected by
// the local router (no backpressure exists, so overflow drops and is flagged)
// and is drained by the core. Both directions keep wrapping traffic counters.
module node_nic #(
  parameter int PKT_W    = 32,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PKT_W-1:0] src_data,
  input  logic             src_val,
  output logic             src_rdy,
  output logic [PKT_W-1:0] net_o_data,
  output logic             net_o_val,
  input  logic             net_i_en,
  input  logic [PKT_W-1:0] net_i_data,
  input  logic             net_i_val,
  output logic [PKT_W-1:0] sink_data,
  output logic             sink_val,
  input  logic             sink_rdy,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] rx_cnt,
  output logic             rx_drop
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  localparam logic [TX_AW:0]    TX_PTR_ONE = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [RX_AW:0]    RX_PTR_ONE = {{RX_AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PKT_W-1:0]  PKT_ZERO   = {PKT_W{1'b0}};

  // Storage and pointers (one extra MSB distinguishes full from empty)
  logic [PKT_W-1:0] r_tx_mem [TX_DEPTH];
  logic [PKT_W-1:0] r_rx_mem [RX_DEPTH];
  logic [TX_AW:0]   r_tx_wptr, r_tx_rptr;
  logic [RX_AW:0]   r_rx_wptr, r_rx_rptr;
  logic [CNT_W-1:0] r_tx_cnt, r_rx_cnt;
  logic             r_rx_drop;

  logic w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_lost;

  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[TX_AW] != r_tx_rptr[TX_AW]) &&
                      (r_tx_wptr[TX_AW-1:0] == r_tx_rptr[TX_AW-1:0]);
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[RX_AW] != r_rx_rptr[RX_AW]) &&
                      (r_rx_wptr[RX_AW-1:0] == r_rx_rptr[RX_AW-1:0]);

  // Handshakes. src_rdy is held low while reset is asserted so nothing is
  // offered as accepted during the reset cycle.
  assign src_rdy   = !reset && !w_tx_full;
  assign w_tx_push = src_val && src_rdy;
  assign net_o_val = !w_tx_empty && net_i_en;
  assign w_tx_pop  = net_o_val;

  // A same-cycle drain frees the slot, so a full RX FIFO can still capture.
  assign sink_val  = !w_rx_empty;
  assign w_rx_pop  = sink_val && sink_rdy;
  assign w_rx_push = net_i_val && (!w_rx_full || w_rx_pop);
  assign w_rx_lost = net_i_val && w_rx_full && !w_rx_pop;

  assign net_o_data = w_tx_empty ? PKT_ZERO : r_tx_mem[r_tx_rptr[TX_AW-1:0]];
  assign sink_data  = w_rx_empty ? PKT_ZERO : r_rx_mem[r_rx_rptr[RX_AW-1:0]];
  assign tx_cnt     = r_tx_cnt;
  assign rx_cnt     = r_rx_cnt;
  assign rx_drop    = r_rx_drop;

  // Packet storage writes; contents are don't-care until a pointer covers them
  always_ff @(posedge clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr[TX_AW-1:0]] <= src_data;
    end
    if (w_rx_push) begin
      r_rx_mem[r_rx_wptr[RX_AW-1:0]] <= net_i_data;
    end
  end

  // TX pointers and injection counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wptr <= {(TX_AW+1){1'b0}};
      r_tx_rptr <= {(TX_AW+1){1'b0}};
      r_tx_cnt  <= {CNT_W{1'b0}};
    end else begin
      if (w_tx_push) begin
        r_tx_wptr <= r_tx_wptr + TX_PTR_ONE;
      end
      if (w_tx_pop) begin
        r_tx_rptr <= r_tx_rptr + TX_PTR_ONE;
        r_tx_cnt  <= r_tx_cnt + CNT_ONE;
      end
    end
  end

  // RX pointers, capture counter and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_wptr <= {(RX_AW+1){1'b0}};
      r_rx_rptr <= {(RX_AW+1){1'b0}};
      r_rx_cnt  <= {CNT_W{1'b0}};
      r_rx_drop <= 1'b0;
    end else begin
      if (w_rx_push) begin
        r_rx_wptr <= r_rx_wptr + RX_PTR_ONE;
        r_rx_cnt  <= r_rx_cnt + CNT_ONE;
      end
      if (w_rx_pop) begin
        r_rx_rptr <= r_rx_rptr + RX_PTR_ONE;
      end
      if (w_rx_lost) begin
        r_rx_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_node_nic.sv
// tb_node_nic: self-checking bench for node_nic. A queue-based model predicts
// every output each cycle; directed sequences add hand-computed literal checks.
module tb_node_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] src_data, net_i_data;
  logic        src_val, net_i_en, net_i_val, sink_rdy;
  logic        src_rdy, net_o_val, sink_val, rx_drop;
  logic [31:0] net_o_data, sink_data;
  logic [15:0] tx_cnt, rx_cnt;

  int total = 0;
  int bad   = 0;

  node_nic #(.PKT_W(32), .TX_DEPTH(4), .RX_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .src_data(src_data), .src_val(src_val), .src_rdy(src_rdy),
    .net_o_data(net_o_data), .net_o_val(net_o_val), .net_i_en(net_i_en),
    .net_i_data(net_i_data), .net_i_val(net_i_val),
    .sink_data(sink_data), .sink_val(sink_val), .sink_rdy(sink_rdy),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: packets as queues, counters as plain numbers
  logic [31:0] m_txq[$];
  logic [31:0] m_rxq[$];
  logic [15:0] m_tx_cnt, m_rx_cnt;
  logic        m_drop;
  logic        e_src_rdy, e_tx_val, e_sink_val, e_push, e_pop_rx;
  logic [31:0] e_tx_data, e_sink_data;

  // Compare process: at each negedge check outputs, then advance the model
  // with the inputs that the next posedge will sample.
  initial begin
    m_tx_cnt = 16'h0; m_rx_cnt = 16'h0; m_drop = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_txq.delete(); m_rxq.delete();
        m_tx_cnt = 16'h0; m_rx_cnt = 16'h0; m_drop = 1'b0;
      end
      e_src_rdy   = !reset && (m_txq.size() < 4);
      e_tx_val    = (m_txq.size() > 0) && net_i_en;
      e_tx_data   = (m_txq.size() > 0) ? m_txq[0] : 32'h0;
      e_sink_val  = (m_rxq.size() > 0);
      e_sink_data = (m_rxq.size() > 0) ? m_rxq[0] : 32'h0;
      chk("src_rdy",    64'(src_rdy),    64'(e_src_rdy));
      chk("net_o_val",  64'(net_o_val),  64'(e_tx_val));
      chk("net_o_data", 64'(net_o_data), 64'(e_tx_data));
      chk("sink_val",   64'(sink_val),   64'(e_sink_val));
      chk("sink_data",  64'(sink_data),  64'(e_sink_data));
      chk("tx_cnt",     64'(tx_cnt),     64'(m_tx_cnt));
      chk("rx_cnt",     64'(rx_cnt),     64'(m_rx_cnt));
      chk("rx_drop",    64'(rx_drop),    64'(m_drop));
      if (!reset) begin
        e_push   = src_val && e_src_rdy;
        e_pop_rx = e_sink_val && sink_rdy;
        if (e_tx_val) begin
          void'(m_txq.pop_front());
          m_tx_cnt = m_tx_cnt + 16'h1;
        end
        if (e_push) m_txq.push_back(src_data);
        if (e_pop_rx) void'(m_rxq.pop_front());
        if (net_i_val) begin
          if (m_rxq.size() < 4) begin
            m_rxq.push_back(net_i_data);
            m_rx_cnt = m_rx_cnt + 16'h1;
          end else begin
            m_drop = 1'b1;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [31:0] exp_rx [4];

  // Directed stimulus
  initial begin
    reset = 1'b1;
    src_data = 32'h0; net_i_data = 32'h0;
    src_val = 1'b0; net_i_en = 1'b0; net_i_val = 1'b0; sink_rdy = 1'b0;
    cyc();
    chk("rst_src_rdy", 64'(src_rdy), 64'h0);
    chk("rst_tx_cnt",  64'(tx_cnt),  64'h0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("rdy_after_rst", 64'(src_rdy), 64'h1);

    // TX streaming with network enabled
    net_i_en = 1'b1;
    src_val = 1'b1; src_data = 32'hA1; cyc();
    chk("tx_a1", 64'(net_o_data), 64'hA1);
    src_data = 32'hA2; cyc();
    chk("tx_a2", 64'(net_o_data), 64'hA2);
    src_data = 32'hA3; cyc();
    chk("tx_a3", 64'(net_o_data), 64'hA3);
    src_val = 1'b0; cyc();
    chk("tx_cnt3", 64'(tx_cnt), 64'h3);
    chk("tx_idle", 64'(net_o_val), 64'h0);

    // TX fill with network disabled: 5 offered, 4 accepted
    net_i_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      src_val = 1'b1; src_data = 32'hD0 + 32'(k); cyc();
    end
    src_val = 1'b0;
    chk("tx_full_rdy", 64'(src_rdy), 64'h0);
    chk("tx_en0_val",  64'(net_o_val), 64'h0);
    net_i_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("tx_drain", 64'(net_o_data), 64'hD0 + 64'(k));
      cyc();
    end
    net_i_en = 1'b0;
    chk("tx_cnt7", 64'(tx_cnt), 64'h7);

    // RX overflow
    for (int k = 0; k < 5; k++) begin
      net_i_val = 1'b1; net_i_data = 32'hB0 + 32'(k); cyc();
    end
    net_i_val = 1'b0;
    chk("rx_cnt4",   64'(rx_cnt),    64'h4);
    chk("rx_drop1",  64'(rx_drop),   64'h1);
    chk("rx_head",   64'(sink_data), 64'hB0);

    // Capture into full FIFO with same-cycle drain
    net_i_val = 1'b1; net_i_data = 32'hC5; sink_rdy = 1'b1; cyc();
    net_i_val = 1'b0;
    chk("rx_cnt5", 64'(rx_cnt), 64'h5);
    exp_rx[0] = 32'hB1; exp_rx[1] = 32'hB2; exp_rx[2] = 32'hB3; exp_rx[3] = 32'hC5;
    for (int k = 0; k < 4; k++) begin
      chk("rx_drain", 64'(sink_data), 64'(exp_rx[k]));
      cyc();
    end
    chk("rx_empty", 64'(sink_val), 64'h0);
    chk("rx_drop_sticky", 64'(rx_drop), 64'h1);

    // Mixed traffic: push, inject, capture and drain coinciding
    for (int i = 0; i < 60; i++) begin
      src_val    = (i % 3) != 0;
      src_data   = 32'hE00 + 32'(i);
      net_i_en   = (i % 4) != 3;
      net_i_val  = (i % 2) == 0;
      net_i_data = 32'hF00 + 32'(i);
      sink_rdy   = (i % 5) != 4;
      cyc();
    end
    src_val = 1'b0; net_i_val = 1'b0; net_i_en = 1'b1; sink_rdy = 1'b1;
    repeat (6) cyc();

    // Reset with 2 TX and 3 RX packets queued
    net_i_en = 1'b0; sink_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      src_val = (k < 2); src_data = 32'h70 + 32'(k);
      net_i_val = 1'b1; net_i_data = 32'h80 + 32'(k);
      cyc();
    end
    src_val = 1'b0; net_i_val = 1'b0;
    chk("pre_rst_sink", 64'(sink_data), 64'h80);
    net_i_en = 1'b1; sink_rdy = 1'b1; reset = 1'b1;
    #1;
    chk("mid_rst_tx_val",  64'(net_o_val),  64'h0);
    chk("mid_rst_tx_data", 64'(net_o_data), 64'h0);
    chk("mid_rst_sink",    64'(sink_val),   64'h0);
    chk("mid_rst_sdata",   64'(sink_data),  64'h0);
    chk("mid_rst_txcnt",   64'(tx_cnt),     64'h0);
    chk("mid_rst_rxcnt",   64'(rx_cnt),     64'h0);
    chk("mid_rst_drop",    64'(rx_drop),    64'h0);
    cyc();
    reset = 1'b0;
    repeat (5) cyc();
    chk("post_rst_txcnt", 64'(tx_cnt), 64'h0);

    // Counter wrap: 65535 injections, then one more
    for (int i = 0; i < 65535; i++) begin
      src_val = 1'b1; src_data = 32'(i); cyc();
    end
    src_val = 1'b0; cyc();
    chk("tx_cnt_ffff", 64'(tx_cnt), 64'hFFFF);
    src_val = 1'b1; src_data = 32'h55; cyc();
    src_val = 1'b0; cyc();
    chk("tx_cnt_wrap", 64'(tx_cnt), 64'h0);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
